// File: rtl/load_store_unit_if.sv
// CPU-side request/response and data_memory-side signals of the load/store unit.
// master: the environment (CPU datapath plus data_memory); slave: the load/store unit.
interface load_store_unit_if;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [31:0] cpu_address;
    logic [31:0] cpu_wdata;
    logic        cpu_write;
    logic [1:0]  cpu_mode;
    logic        cpu_unsigned;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_misaligned;
    logic [31:0] mem_address;
    logic [1:0]  mem_mode;
    logic        mem_unsigned;
    logic        mem_wren;
    logic [31:0] mem_data;
    logic [31:0] mem_q;

    modport master (
        output cpu_valid, cpu_address, cpu_wdata, cpu_write, cpu_mode, cpu_unsigned, mem_q,
        input  cpu_ready, cpu_done, cpu_rdata, cpu_misaligned,
        input  mem_address, mem_mode, mem_unsigned, mem_wren, mem_data
    );

    modport slave (
        input  cpu_valid, cpu_address, cpu_wdata, cpu_write, cpu_mode, cpu_unsigned, mem_q,
        output cpu_ready, cpu_done, cpu_rdata, cpu_misaligned,
        output mem_address, mem_mode, mem_unsigned, mem_wren, mem_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time towards data_memory. Misaligned half/word
// accesses are split into sequential unsigned byte accesses and reassembled.
module load_store_unit #(
    parameter int unsigned READ_LATENCY = 1  // must be >= 1
) (
    input logic              clock,
    input logic              reset,  // asynchronous, active-low
    load_store_unit_if.slave bus
);
    localparam logic [1:0] MemByte = 2'd0;
    localparam logic [1:0] MemHalf = 2'd1;
    localparam logic [1:0] MemWord = 2'd2;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q;
    logic        write_q, unsigned_q, split_q;
    logic [1:0]  mode_q;
    logic [1:0]  last_idx_q;  // N-1
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] maddr_q, mdata_q;
    logic [1:0]  mmode_q;
    logic        muns_q;

    logic        accept, req_split, last_access;
    logic [31:0] acc_addr, acc_data, asm_next, load_result;
    logic [1:0]  acc_mode;
    logic        acc_uns;

    assign accept    = (state_q == StIdle) && bus.cpu_valid;
    assign req_split = ((bus.cpu_mode == MemHalf) && (bus.cpu_address[1:0] == 2'd3)) ||
                       ((bus.cpu_mode == MemWord) && (bus.cpu_address[1:0] != 2'd0));

    // Parameters of access idx_q for the latched request.
    assign acc_addr    = split_q ? addr_q + {30'd0, idx_q} : addr_q;
    assign acc_mode    = split_q ? MemByte : mode_q;
    assign acc_uns     = split_q ? 1'b1 : unsigned_q;
    assign acc_data    = split_q ? {24'd0, wdata_q[{idx_q, 3'b000} +: 8]} : wdata_q;
    assign last_access = (idx_q == last_idx_q);

    assign asm_next = asm_q | ({24'd0, bus.mem_q[7:0]} << {idx_q, 3'b000});

    // Final load value: aligned loads are already extended by the memory.
    always_comb begin
        load_result = bus.mem_q;
        if (split_q) begin
            if (mode_q == MemHalf) begin
                load_result = {unsigned_q ? 16'h0000 : {16{asm_next[15]}}, asm_next[15:0]};
            end else begin
                load_result = asm_next;
            end
        end
    end

    // State and progress registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            wait_q  <= 8'd0;
            asm_q   <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state: issue each access, wait out the read latency, then pulse done.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StIssue;
                    idx_d   = 2'd0;
                    asm_d   = 32'd0;
                end
            end
            StIssue: begin
                wait_d = 8'd0;
                if (!write_q) begin
                    state_d = StWait;
                end else if (last_access) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            StWait: begin
                if (wait_q == 8'(READ_LATENCY - 1)) begin
                    asm_d = asm_next;
                    if (last_access) begin
                        rdata_d = load_result;
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = StIssue;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Latch the request on accept; cpu_misaligned follows split_q until the next accept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            write_q    <= 1'b0;
            mode_q     <= MemByte;
            unsigned_q <= 1'b0;
            split_q    <= 1'b0;
            last_idx_q <= 2'd0;
        end else if (accept) begin
            addr_q     <= bus.cpu_address;
            wdata_q    <= bus.cpu_wdata;
            write_q    <= bus.cpu_write;
            mode_q     <= bus.cpu_mode;
            unsigned_q <= bus.cpu_unsigned;
            split_q    <= req_split;
            last_idx_q <= !req_split ? 2'd0 : (bus.cpu_mode == MemHalf) ? 2'd1 : 2'd3;
        end
    end

    // Hold the last issued memory controls: data_memory applies mode/unsigned at its output.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            maddr_q <= 32'd0;
            mmode_q <= MemByte;
            muns_q  <= 1'b0;
            mdata_q <= 32'd0;
        end else if (state_q == StIssue) begin
            maddr_q <= acc_addr;
            mmode_q <= acc_mode;
            muns_q  <= acc_uns;
            mdata_q <= acc_data;
        end
    end

    assign bus.mem_address    = (state_q == StIssue) ? acc_addr : maddr_q;
    assign bus.mem_mode       = (state_q == StIssue) ? acc_mode : mmode_q;
    assign bus.mem_unsigned   = (state_q == StIssue) ? acc_uns  : muns_q;
    assign bus.mem_data       = (state_q == StIssue) ? acc_data : mdata_q;
    assign bus.mem_wren       = (state_q == StIssue) && write_q;
    assign bus.cpu_ready      = (state_q == StIdle);
    assign bus.cpu_done       = (state_q == StDone);
    assign bus.cpu_rdata      = rdata_q;
    assign bus.cpu_misaligned = split_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed data_memory model, directed vector table,
// hand sequences for held-valid and mid-operation reset, and random requests checked
// against a request-level memory model.
module tb_load_store_unit;
    localparam logic [1:0] MB = 2'd0;
    localparam logic [1:0] MH = 2'd1;
    localparam logic [1:0] MW = 2'd2;

    logic clock = 1'b0;
    logic reset = 1'b0;

    load_store_unit_if bus ();

    load_store_unit #(.READ_LATENCY(1)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    logic [7:0] phys [logic [31:0]];  // contents seen by the DUT
    logic [7:0] refm [logic [31:0]];  // request-level reference contents

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    logic [31:0] last_load = 32'd0;

    logic [31:0] wa [4];
    logic [31:0] wdt [4];
    logic [1:0]  wm [4];
    int          wcnt;
    logic [1:0]  done_mode;
    logic        done_uns;

    typedef struct {
        logic        wr;
        logic [1:0]  md;
        logic        un;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [31:0] rd;
        int          lat;
        logic        mis;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [31:0] ext(input logic [31:0] v, input logic [1:0] m,
                                        input logic u);
        case (m)
            2'd0:    return u ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            2'd1:    return u ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic int size_of(input logic [1:0] m);
        return (m == MB) ? 1 : (m == MH) ? 2 : 4;
    endfunction

    function automatic logic [7:0] phys_rd(input logic [31:0] a);
        return phys.exists(a) ? phys[a] : 8'h00;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] ad, input logic [1:0] m,
                                               input logic u);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < size_of(m); i++) begin
            logic [31:0] a = ad + 32'(i);
            v[8*i +: 8] = refm.exists(a) ? refm[a] : 8'h00;
        end
        return ext(v, m, u);
    endfunction

    function automatic logic model_mis(input logic [1:0] m, input logic [31:0] ad);
        return (m == MH && ad[1:0] == 2'd3) || (m == MW && ad[1:0] != 2'd0);
    endfunction

    function automatic int model_n(input logic [1:0] m, input logic [31:0] ad);
        return model_mis(m, ad) ? size_of(m) : 1;
    endfunction

    // data_memory model: inputs registered on the rising edge, q valid one cycle later.
    initial begin
        logic        s_wren, s_uns;
        logic [31:0] s_addr, s_data;
        logic [1:0]  s_mode;
        bus.mem_q = 32'd0;
        forever begin
            @(negedge clock);
            s_wren = bus.mem_wren;
            s_addr = bus.mem_address;
            s_data = bus.mem_data;
            s_mode = bus.mem_mode;
            s_uns  = bus.mem_unsigned;
            @(posedge clock);
            if (s_wren) begin
                for (int i = 0; i < size_of(s_mode); i++) phys[s_addr + 32'(i)] = s_data[8*i +: 8];
            end
            bus.mem_q <= ext({phys_rd(s_addr + 32'd3), phys_rd(s_addr + 32'd2),
                              phys_rd(s_addr + 32'd1), phys_rd(s_addr)}, s_mode, s_uns);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic wait_ready();
        @(negedge clock);
        for (int k = 0; k < 20 && !bus.cpu_ready; k++) @(negedge clock);
    endtask

    // Issue one request, record writes seen, return latency (0 = no done within budget).
    task automatic do_req(input logic wr, input logic [1:0] md, input logic un,
                          input logic [31:0] ad, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic mis);
        wait_ready();
        bus.cpu_valid    = 1'b1;
        bus.cpu_write    = wr;
        bus.cpu_mode     = md;
        bus.cpu_unsigned = un;
        bus.cpu_address  = ad;
        bus.cpu_wdata    = wd;
        @(posedge clock);
        #1;
        bus.cpu_valid = 1'b0;
        lat  = 0;
        wcnt = 0;
        for (int k = 1; k <= 60; k++) begin
            if (bus.mem_wren) begin
                if (wcnt < 4) begin
                    wa[wcnt]  = bus.mem_address;
                    wdt[wcnt] = bus.mem_data;
                    wm[wcnt]  = bus.mem_mode;
                end
                wcnt++;
            end
            if (bus.cpu_done) begin
                lat = k;
                break;
            end
            @(posedge clock);
            #1;
        end
        rd        = bus.cpu_rdata;
        mis       = bus.cpu_misaligned;
        done_mode = bus.mem_mode;
        done_uns  = bus.mem_unsigned;
    endtask

    task automatic run_and_check(input string name, input logic wr, input logic [1:0] md,
                                 input logic un, input logic [31:0] ad, input logic [31:0] wd,
                                 input logic [31:0] exp_rd, input int exp_lat,
                                 input logic exp_mis);
        int          lat;
        logic [31:0] rd;
        logic        mis;
        logic        split = model_mis(md, ad);
        int          n = model_n(md, ad);
        do_req(wr, md, un, ad, wd, lat, rd, mis);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " rdata"}, rd, exp_rd);
        check({name, " misaligned"}, {31'd0, mis}, {31'd0, exp_mis});
        check({name, " wren cycles"}, 32'(wcnt), wr ? 32'(n) : 32'd0);
        check({name, " held mode"}, {30'd0, done_mode}, {30'd0, split ? MB : md});
        check({name, " held unsigned"}, {31'd0, done_uns}, {31'd0, split ? 1'b1 : un});
        if (wr) begin
            for (int i = 0; i < n && i < wcnt; i++) begin
                check({name, " wr addr"}, wa[i], split ? ad + 32'(i) : ad);
                check({name, " wr data"}, wdt[i], split ? {24'd0, wd[8*i +: 8]} : wd);
                check({name, " wr mode"}, {30'd0, wm[i]}, {30'd0, split ? MB : md});
            end
            for (int i = 0; i < size_of(md); i++) refm[ad + 32'(i)] = wd[8*i +: 8];
        end else begin
            last_load = exp_rd;
        end
    endtask

    initial begin
        int          lat, busy_err, dones;
        logic [31:0] exp;
        logic        wr, un;
        logic [1:0]  md;
        logic [31:0] ad, wd;

        bus.cpu_valid    = 1'b0;
        bus.cpu_write    = 1'b0;
        bus.cpu_mode     = MB;
        bus.cpu_unsigned = 1'b0;
        bus.cpu_address  = 32'd0;
        bus.cpu_wdata    = 32'd0;

        //            wr    md  un    addr           wdata          rdata          lat mis
        tbl[0]  = '{1'b1, MW, 1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 2, 1'b0};
        tbl[1]  = '{1'b0, MW, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 3, 1'b0};
        tbl[2]  = '{1'b1, MH, 1'b0, 32'h0000_0003, 32'h0000_BEEF, 32'h1234_5678, 3, 1'b1};
        tbl[3]  = '{1'b0, MH, 1'b0, 32'h0000_0003, 32'h0,         32'hFFFF_BEEF, 5, 1'b1};
        tbl[4]  = '{1'b0, MH, 1'b1, 32'h0000_0003, 32'h0,         32'h0000_BEEF, 5, 1'b1};
        tbl[5]  = '{1'b1, MW, 1'b0, 32'h0000_0001, 32'hAABB_CCDD, 32'h0000_BEEF, 5, 1'b1};
        tbl[6]  = '{1'b0, MW, 1'b0, 32'h0000_0001, 32'h0,         32'hAABB_CCDD, 9, 1'b1};
        tbl[7]  = '{1'b1, MB, 1'b0, 32'h0000_0006, 32'h0000_0080, 32'hAABB_CCDD, 2, 1'b0};
        tbl[8]  = '{1'b0, MB, 1'b0, 32'h0000_0006, 32'h0,         32'hFFFF_FF80, 3, 1'b0};
        tbl[9]  = '{1'b0, MB, 1'b1, 32'h0000_0006, 32'h0,         32'h0000_0080, 3, 1'b0};
        tbl[10] = '{1'b1, MW, 1'b0, 32'hFFFF_FFFF, 32'h1122_3344, 32'h0000_0080, 5, 1'b1};
        tbl[11] = '{1'b0, MW, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h1122_3344, 9, 1'b1};

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check("reset cpu_done", {31'd0, bus.cpu_done}, 32'd0);
        check("reset cpu_rdata", bus.cpu_rdata, 32'd0);
        check("reset mem_wren", {31'd0, bus.mem_wren}, 32'd0);
        check("reset mem_address", bus.mem_address, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("ready after release", {31'd0, bus.cpu_ready}, 32'd1);
        check("misaligned after release", {31'd0, bus.cpu_misaligned}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_and_check($sformatf("vec%0d", i), tbl[i].wr, tbl[i].md, tbl[i].un, tbl[i].ad,
                          tbl[i].wd, tbl[i].rd, tbl[i].lat, tbl[i].mis);
        end

        // cpu_valid held high across a split load: no second accept before done.
        exp = model_load(32'h3, MH, 1'b0);
        wait_ready();
        bus.cpu_valid    = 1'b1;
        bus.cpu_write    = 1'b0;
        bus.cpu_mode     = MH;
        bus.cpu_unsigned = 1'b0;
        bus.cpu_address  = 32'h3;
        @(posedge clock);
        #1;
        lat = 0;
        busy_err = 0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.cpu_ready) busy_err++;
            if (bus.cpu_done) begin
                lat = k;
                break;
            end
            @(posedge clock);
            #1;
        end
        check("hold latency", 32'(lat), 32'd5);
        check("hold ready low", 32'(busy_err), 32'd0);
        check("hold rdata", bus.cpu_rdata, exp);
        @(posedge clock);
        #1;
        check("hold ready after done", {31'd0, bus.cpu_ready}, 32'd1);
        bus.cpu_valid = 1'b0;
        @(posedge clock);
        #1;
        check("hold no extra accept", {31'd0, bus.cpu_ready}, 32'd1);
        last_load = exp;

        // Random requests against the request-level model.
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            md = 2'($urandom_range(0, 2));
            un = 1'($urandom_range(0, 1));
            ad = 32'($urandom_range(0, 31));
            wd = $urandom;
            exp = wr ? last_load : model_load(ad, md, un);
            run_and_check("rand", wr, md, un, ad, wd, exp,
                          1 + model_n(md, ad) * (wr ? 1 : 2), model_mis(md, ad));
        end

        // Reset during the second byte of a split store.
        wait_ready();
        bus.cpu_valid    = 1'b1;
        bus.cpu_write    = 1'b1;
        bus.cpu_mode     = MW;
        bus.cpu_unsigned = 1'b0;
        bus.cpu_address  = 32'h201;
        bus.cpu_wdata    = 32'h5566_7788;
        @(posedge clock);
        #1;
        bus.cpu_valid = 1'b0;
        @(posedge clock);
        #1;
        check("abort second wren", {31'd0, bus.mem_wren}, 32'd1);
        check("abort second addr", bus.mem_address, 32'h202);
        #1;
        reset = 1'b0;
        #1;
        check("abort mem_wren", {31'd0, bus.mem_wren}, 32'd0);
        check("abort cpu_done", {31'd0, bus.cpu_done}, 32'd0);
        check("abort cpu_rdata", bus.cpu_rdata, 32'd0);
        check("abort misaligned", {31'd0, bus.cpu_misaligned}, 32'd0);
        check("abort mem_address", bus.mem_address, 32'd0);
        check("abort mem_mode", {30'd0, bus.mem_mode}, 32'd0);
        check("abort mem_unsigned", {31'd0, bus.mem_unsigned}, 32'd0);
        check("abort mem_data", bus.mem_data, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock);
            #1;
            if (bus.cpu_done) dones++;
        end
        check("abort no done", 32'(dones), 32'd0);
        check("abort ready", {31'd0, bus.cpu_ready}, 32'd1);
        check("abort first byte kept", {24'd0, phys_rd(32'h201)}, 32'h88);
        check("abort second byte absent", {24'd0, phys_rd(32'h202)}, 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data memory port: accepts one load/store request at a time from the CPU datapath and drives data_memory's address/mode/unsigned/wren/data inputs.
- Returns the read result to the CPU datapath.
- Splits misaligned accesses into sequential byte accesses, because the memory only shifts within one word (half at offset 3; word at offset 1–3).
- Sits between the execute stage and data_memory and handles its registered read latency.

Parameters:
- READ_LATENCY, 1: cycles from the mem_address issue cycle until mem_q is valid (data_memory registers its inputs).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_valid  in  1  request present
- cpu_ready  out  1  unit can accept a request
- cpu_address  in  32  byte address
- cpu_wdata  in  32  store data, right-aligned
- cpu_write  in  1  1 = store, 0 = load
- cpu_mode  in  2  MEM_BYTE/MEM_HALF/MEM_WORD (mem_modes.h encoding)
- cpu_unsigned  in  1  zero-extend load result
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  32  extended load result
- cpu_misaligned  out  1  current/last access was split
- mem_address  out  32  to data_memory address
- mem_mode  out  2  to data_memory mem_mode
- mem_unsigned  out  1  to data_memory mem_unsigned
- mem_wren  out  1  to data_memory wren
- mem_data  out  32  to data_memory data
- mem_q  in  32  from data_memory q

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - cpu_done, cpu_rdata, cpu_misaligned, mem_address, mem_mode, mem_unsigned, mem_wren and mem_data are all 0.
  - cpu_ready = 1 after release.
- States:
  - IDLE: cpu_ready = 1. cpu_valid && cpu_ready at edge T latches the request and computes N, then goes to ISSUE.
  - ISSUE: drives access i for exactly one cycle. Loads go to WAIT; stores go to ISSUE (i+1) or DONE.
  - WAIT: counts READ_LATENCY cycles, then captures mem_q. Goes to ISSUE (i+1) or DONE.
  - DONE: cpu_done = 1 for one cycle, then IDLE.
- cpu_ready is 0 in every state except IDLE. cpu_valid outside IDLE is ignored, with no queueing.
- N (number of accesses):
  - Misaligned = (HALF && addr[1:0]==3) || (WORD && addr[1:0]!=0).
  - Aligned (any BYTE, HALF at offset 0–2, WORD at offset 0): N=1, using mem_address=addr, mem_mode=cpu_mode, mem_unsigned=cpu_unsigned, mem_data=cpu_wdata.
  - Misaligned: N=2 (HALF) or 4 (WORD). Access i uses mem_address=addr+i (32-bit wrap, 0xFFFFFFFF+1=0), mem_mode=MEM_BYTE, mem_unsigned=1, mem_data={24'b0, cpu_wdata[8i+7:8i]}.
- mem_wren is high only during ISSUE cycles of stores.
- mem_address, mem_mode and mem_unsigned hold their values through WAIT and DONE, and after return to IDLE until the next ISSUE. This is required because data_memory applies mem_unsigned/mode at its output stage.
- Load capture:
  - Aligned: cpu_rdata = mem_q.
  - Split: mem_q[7:0] is placed in assembly bits [8i+7:8i]. At the end, the result is extended from bit 15 (HALF) or taken as-is (WORD); zero extension if cpu_unsigned.
- cpu_rdata updates only when a load completes, and holds otherwise. Stores leave cpu_rdata unchanged.
- Latency, with accept at edge T:
  - Load: cpu_done high in cycle T+1+N*(1+READ_LATENCY). Aligned, RL=1: T+3.
  - Store: cpu_done high in cycle T+1+N. Aligned: T+2.
- Next accept is no earlier than the cycle after DONE.
- cpu_misaligned is registered at accept and held until the next accept.
- No region or IO-boundary checks; a split access may cross the RAM/IO boundary.
- Reset mid-operation aborts: mem_wren drops immediately. Already-issued byte writes are not undone, and no cpu_done is produced.

Test Plan:
- Store WORD 0x12345678 @0x010, then load WORD @0x010 → one mem_wren cycle at 0x010; cpu_rdata=0x12345678; load cpu_done at T+3; cpu_misaligned=0.
- Store HALF 0xBEEF @0x003 → byte writes 0xEF@0x003, 0xBE@0x004, mode MEM_BYTE, done at T+3. Load HALF signed @0x003 → 0xFFFFBEEF; unsigned → 0x0000BEEF; load done at T+5; cpu_misaligned=1.
- Store WORD 0xAABBCCDD @0x001 → 4 byte writes 0xDD,0xCC,0xBB,0xAA at 0x001..0x004. Load WORD @0x001 → 0xAABBCCDD at T+9.
- Byte 0x80 at @0x006: load BYTE signed → 0xFFFFFF80; unsigned → 0x00000080. mem_unsigned is held stable through capture.
- cpu_valid held high during a split load → cpu_ready=0 and no second accept until after cpu_done. Store WORD @0xFFFFFFFF → addresses 0xFFFFFFFF, 0x0, 0x1, 0x2.
- Assert reset during the 2nd byte of a split store → mem_wren=0 same cycle; all outputs 0; no cpu_done; cpu_ready=1 after release.
